serial_subtractor: RTL and testbench

// - Bit-serial unsigned subtractor: diff = a - b, plus final borrow.
// - Complements the combinational adder cells of the arithmetic lab set.
// - Processes one bit per clock, LSB first, through a single 1-bit

---
 rtl/serial_subtractor_pkg.sv | 10 +
 rtl/full_subtractor.sv | 17 +
 rtl/serial_subtractor.sv | 101 ++++++++++
 tb/tb_serial_subtractor.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Package sub_pkg: shared types and limits for the bit-serial subtractor.
//   ser_state_t - control FSM states (IDLE, SHIFT, DONE)
//   MAX_WIDTH   - largest supported operand width
package sub_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} ser_state_t;

    localparam int unsigned MAX_WIDTH = 32;

endpackage : sub_pkg

// File: rtl/full_subtractor.sv
// full_subtractor: combinational 1-bit full-subtractor cell (a - b - bin).
//   a, b  - operand bits
//   bin   - borrow in
//   d     - difference bit
//   bout  - borrow out
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned subtractor, diff = a - b, LSB first,
// one bit per clock through a single full_subtractor cell.
//   clk, rst_n          - clock (rising edge), async active-low reset
//   in_valid / in_ready - operand handshake (a, b)
//   out_valid/ out_ready- result handshake (diff, borrow)
//   diff                - (a - b) mod 2^WIDTH
//   borrow              - 1 iff a < b
module serial_subtractor
    import sub_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int unsigned   CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    ser_state_t       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] d_sh;
    logic [CW-1:0]    cnt;
    logic             bq;
    logic             d_bit;
    logic             b_next;

    full_subtractor u_fs (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .bin  (bq),
        .d    (d_bit),
        .bout (b_next)
    );

    // The borrow FF holds the final borrow once the last bit has been processed.
    assign diff   = d_sh;
    assign borrow = bq;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            a_sh      <= '0;
            b_sh      <= '0;
            d_sh      <= '0;
            cnt       <= '0;
            bq        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_sh     <= a;
                        b_sh     <= b;
                        bq       <= 1'b0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    d_sh <= {d_bit, d_sh[WIDTH-1:1]};
                    bq   <= b_next;
                    // Counter wraps to zero on the final bit so it never exceeds WIDTH-1.
                    if (cnt == CNT_LAST) begin
                        cnt       <= '0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int vec  = 0;
  int miss = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec++;
    if (obs !== exp) begin
      miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic       in_valid8, in_ready8, out_valid8, out_ready8, borrow8;
  logic [7:0] a8, b8, diff8;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .a         (a8),
    .b         (b8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .diff      (diff8),
    .borrow    (borrow8)
  );

  logic       in_valid2, in_ready2, out_valid2, out_ready2, borrow2;
  logic [1:0] a2, b2, diff2;

  serial_subtractor #(.WIDTH(2)) dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid2),
    .in_ready  (in_ready2),
    .a         (a2),
    .b         (b2),
    .out_valid (out_valid2),
    .out_ready (out_ready2),
    .diff      (diff2),
    .borrow    (borrow2)
  );

  function automatic logic [8:0] ref_sub8(input logic [7:0] x, input logic [7:0] y);
    int r;
    r = int'(x) - int'(y);
    return {(r < 0), 8'(r)};
  endfunction

  function automatic logic [2:0] ref_sub2(input logic [1:0] x, input logic [1:0] y);
    int r;
    r = int'(x) - int'(y);
    return {(r < 0), 2'(r)};
  endfunction

  task automatic op8(input logic [7:0] x, input logic [7:0] y,
                     input int hold, input bit inject);
    logic [8:0] exp_r;
    int lat;
    exp_r = ref_sub8(x, y);
    out_ready8 = (hold == 0);
    in_valid8 = 1'b1;
    a8 = x;
    b8 = y;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    a8 = 8'($urandom);
    b8 = 8'($urandom);
    chk("in_ready_low_after_accept", 64'(in_ready8), 64'(1'b0));
    lat = 0;
    while (!out_valid8 && lat < 40) begin
      if (inject && lat == 2) begin
        in_valid8 = 1'b1;
        a8 = 8'h10;
        b8 = 8'h01;
      end
      if (inject && lat == 4) in_valid8 = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    in_valid8 = 1'b0;
    chk("latency8", 64'(lat), 64'(8));
    chk("diff8", 64'(diff8), 64'(exp_r[7:0]));
    chk("borrow8", 64'(borrow8), 64'(exp_r[8]));
    for (int unsigned i = 0; i < unsigned'(hold); i++) begin
      @(posedge clk); #1;
      chk("hold_stable", 64'({out_valid8, in_ready8, borrow8, diff8}),
          64'({1'b1, 1'b0, exp_r[8], exp_r[7:0]}));
    end
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    out_ready8 = 1'b0;
    chk("consumed_out_valid", 64'(out_valid8), 64'(1'b0));
    chk("back_idle_in_ready", 64'(in_ready8), 64'(1'b1));
  endtask

  task automatic op2(input logic [1:0] x, input logic [1:0] y);
    logic [2:0] exp_r;
    int lat;
    exp_r = ref_sub2(x, y);
    out_ready2 = 1'b1;
    in_valid2 = 1'b1;
    a2 = x;
    b2 = y;
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    lat = 0;
    while (!out_valid2 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency2", 64'(lat), 64'(2));
    chk("result2", 64'({borrow2, diff2}), 64'(exp_r));
    @(posedge clk); #1;
    chk("consumed2", 64'({out_valid2, in_ready2}), 64'(2'b01));
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0;
    in_valid2 = 1'b0; out_ready2 = 1'b0; a2 = '0; b2 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset8", 64'({in_ready8, out_valid8, borrow8, diff8}), 64'({1'b1, 1'b0, 1'b0, 8'h00}));
    chk("reset2", 64'({in_ready2, out_valid2, borrow2, diff2}), 64'({1'b1, 1'b0, 1'b0, 2'b00}));
    rst_n = 1'b1;
    @(posedge clk); #1;

    op8(8'h05, 8'h03, 0, 1'b0);
    op8(8'h03, 8'h05, 0, 1'b0);
    op8(8'h00, 8'h01, 0, 1'b0);
    op8(8'hA5, 8'hA5, 0, 1'b0);
    op8(8'hFF, 8'h00, 0, 1'b0);
    op8(8'h00, 8'hFF, 0, 1'b0);

    op8(8'h9C, 8'h3E, 20, 1'b0);

    op8(8'h40, 8'h20, 0, 1'b1);
    begin
      int extra;
      extra = 0;
      for (int unsigned i = 0; i < 15; i++) begin
        @(posedge clk); #1;
        if (out_valid8) extra++;
      end
      chk("no_second_result", 64'(extra), 64'(0));
    end

    in_valid8 = 1'b1;
    a8 = 8'h77;
    b8 = 8'h11;
    out_ready8 = 1'b1;
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midop_reset", 64'({in_ready8, out_valid8, borrow8, diff8}), 64'({1'b1, 1'b0, 1'b0, 8'h00}));
    @(posedge clk); #1;
    chk("midop_reset_held", 64'({in_ready8, out_valid8}), 64'(2'b10));
    rst_n = 1'b1;
    @(posedge clk); #1;
    op8(8'h80, 8'h7F, 0, 1'b0);

    for (int unsigned n = 0; n < 30; n++) begin
      op8(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)), 1'b0);
    end

    for (int unsigned x = 0; x < 4; x++) begin
      for (int unsigned y = 0; y < 4; y++) begin
        op2(2'(x), 2'(y));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule : tb_serial_subtractor
